// File: rtl/jk_excitation_driver.sv
// -----------------------------------------------------------------------------
// jk_excitation_driver
//
// Write side of a JK flip-flop bank. The block accepts target state words over
// a valid/ready handshake, converts each into a one-cycle J/K excitation for
// the bank, waits one cycle for the bank to settle, then compares the bank's Q
// feedback against the target. The bank state is tracked in a shadow register
// so the block can skip the excitation when the requested word is unchanged.
//
// Optional build macro:
//   JK_TOGGLE_ENCODE_EN  When defined, every changing bit is driven J=1,K=1
//                        (toggle). When undefined, changing bits are driven
//                        with set (J=1,K=0) or reset (J=0,K=1) encoding.
//                        Timing, checking and counting are the same in both.
//
// Parameters:
//   WIDTH   number of JK flip-flops driven (1..32)
//   CNT_W   width of the saturating toggle counter
//
// Ports:
//   clk         in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   tgt_valid   in   target word offered
//   tgt_data    in   requested next state of the JK bank
//   tgt_ready   out  driver can accept a target (IDLE)
//   j_out       out  J inputs to the JK bank
//   k_out       out  K inputs to the JK bank
//   exc_valid   out  j_out/k_out carry a live excitation this cycle
//   q_fb        in   Q outputs fed back from the JK bank
//   clr_err     in   clears the sticky mismatch flag
//   mismatch    out  sticky: bank state differed from target at check time
//   busy        out  FSM not in IDLE
//   toggle_cnt  out  total bits changed, saturating
// -----------------------------------------------------------------------------
module jk_excitation_driver #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             exc_valid,
    input  logic [WIDTH-1:0] q_fb,
    input  logic             clr_err,
    output logic             mismatch,
    output logic             busy,
    output logic [CNT_W-1:0] toggle_cnt
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRIVE  = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_CHECK  = 2'd3;

    // Popcount of a WIDTH-bit word and a sum wide enough to never wrap
    localparam int unsigned POP_W = $clog2(WIDTH + 1);
    localparam int unsigned SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] tgt_q,    tgt_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] j_q,      j_d;
    logic [WIDTH-1:0] k_q,      k_d;
    logic             exc_q,    exc_d;
    logic             mm_q,     mm_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             busy_q,   busy_d;
    logic             rdy_q,    rdy_d;

    logic             accept;
    logic             set_mm;
    logic [WIDTH-1:0] enc_j;
    logic [WIDTH-1:0] enc_k;
    logic [POP_W-1:0] pop;
    logic [SUM_W-1:0] cnt_sum;
    logic [CNT_W-1:0] cnt_sat;

    // Excitation encoding from current shadow state and the offered target
    always_comb begin
        enc_j = '0;
        enc_k = '0;
`ifdef JK_TOGGLE_ENCODE_EN
        enc_j = shadow_q ^ tgt_data;
        enc_k = shadow_q ^ tgt_data;
`else
        enc_j = ~shadow_q &  tgt_data;
        enc_k =  shadow_q & ~tgt_data;
`endif
    end

    // Number of bits changing in the transfer currently in DRIVE
    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pop = pop + POP_W'(shadow_q[i] ^ tgt_q[i]);
        end
    end

    // Saturating accumulate of changed bits
    always_comb begin
        cnt_sum = SUM_W'(cnt_q) + SUM_W'(pop);
        cnt_sat = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(cnt_sum);
    end

    assign accept = tgt_valid && rdy_q && (state_q == ST_IDLE);

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        shadow_d = shadow_q;
        j_d      = '0;
        k_d      = '0;
        exc_d    = 1'b0;
        cnt_d    = cnt_q;
        set_mm   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    tgt_d = tgt_data;
                    if (tgt_data != shadow_q) begin
                        // Excitation is registered so it appears in DRIVE
                        state_d = ST_DRIVE;
                        exc_d   = 1'b1;
                        j_d     = enc_j;
                        k_d     = enc_k;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_DRIVE: begin
                cnt_d   = cnt_sat;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                // Shadow follows the target even on a failed compare
                set_mm   = (q_fb != tgt_q);
                shadow_d = tgt_q;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Sticky flag; a set in the same cycle as a clear wins
        mm_d   = set_mm | (mm_q & ~clr_err);
        busy_d = (state_d != ST_IDLE);
        rdy_d  = (state_d == ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            tgt_q    <= '0;
            shadow_q <= '0;
            j_q      <= '0;
            k_q      <= '0;
            exc_q    <= 1'b0;
            mm_q     <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            rdy_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            shadow_q <= shadow_d;
            j_q      <= j_d;
            k_q      <= k_d;
            exc_q    <= exc_d;
            mm_q     <= mm_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            rdy_q    <= rdy_d;
        end
    end

    assign tgt_ready  = rdy_q;
    assign j_out      = j_q;
    assign k_out      = k_q;
    assign exc_valid  = exc_q;
    assign mismatch   = mm_q;
    assign busy       = busy_q;
    assign toggle_cnt = cnt_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// -----------------------------------------------------------------------------
// tb_jk_excitation_driver
//
// Scoreboard bench for jk_excitation_driver. The driver computes the expected
// outcome of each transfer from a small behavioural model (shadow word, count,
// sticky flag) and queues it; a negedge monitor collects what the DUT shows
// during each busy window and checks it against the queued entry when the
// transfer completes. A simple JK bank model closes the q_fb loop, with an
// override used to provoke mismatches.
// -----------------------------------------------------------------------------
module tb_jk_excitation_driver;

    localparam int unsigned W = 4;
    localparam int unsigned C = 8;
    localparam int unsigned CMAX = (1 << C) - 1;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         tgt_valid = 1'b0;
    logic [W-1:0] tgt_data = '0;
    logic         tgt_ready;
    logic [W-1:0] j_out;
    logic [W-1:0] k_out;
    logic         exc_valid;
    logic [W-1:0] q_fb;
    logic         clr_err = 1'b0;
    logic         mismatch;
    logic         busy;
    logic [C-1:0] toggle_cnt;

    logic [W-1:0] bank_q;
    logic         fb_force = 1'b0;
    logic [W-1:0] fb_val = '0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         chg;
        logic [W-1:0] j;
        logic [W-1:0] k;
        logic [C-1:0] cnt;
        logic         mm;
    } exp_t;

    exp_t sb[$];

    // Behavioural model state
    logic [W-1:0] m_shadow = '0;
    int           m_cnt = 0;
    logic         m_mm = 1'b0;

    jk_excitation_driver #(.WIDTH(W), .CNT_W(C)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tgt_valid  (tgt_valid),
        .tgt_data   (tgt_data),
        .tgt_ready  (tgt_ready),
        .j_out      (j_out),
        .k_out      (k_out),
        .exc_valid  (exc_valid),
        .q_fb       (q_fb),
        .clr_err    (clr_err),
        .mismatch   (mismatch),
        .busy       (busy),
        .toggle_cnt (toggle_cnt)
    );

    always #5 clk = ~clk;

    // JK bank: Q+ = J&~Q | ~K&Q
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) bank_q <= '0;
        else          bank_q <= (j_out & ~bank_q) | (~k_out & bank_q);
    end

    assign q_fb = fb_force ? fb_val : bank_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected J/K per bit from the excitation table
    function automatic logic [2*W-1:0] exp_jk(input logic [W-1:0] s, input logic [W-1:0] t);
        logic [W-1:0] j;
        logic [W-1:0] k;
        j = '0;
        k = '0;
        for (int i = 0; i < W; i++) begin
`ifdef JK_TOGGLE_ENCODE_EN
            if (s[i] != t[i]) begin j[i] = 1'b1; k[i] = 1'b1; end
`else
            if (!s[i] && t[i]) j[i] = 1'b1;
            if (s[i] && !t[i]) k[i] = 1'b1;
`endif
        end
        return {j, k};
    endfunction

    // Monitor: collect observations over each busy window, score on completion
    bit           prev_busy = 1'b0;
    int           n_exc = 0;
    int           n_busy = 0;
    logic [W-1:0] cap_j = '0;
    logic [W-1:0] cap_k = '0;
    exp_t         mon_e;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_busy = 1'b0;
            n_exc     = 0;
            n_busy    = 0;
        end else begin
            if (exc_valid) begin
                n_exc++;
                cap_j = j_out;
                cap_k = k_out;
            end else begin
                chk("jk_zero_outside_drive", 32'({j_out, k_out}), 32'd0);
            end
            if (busy) begin
                n_busy++;
                chk("ready_low_while_busy", 32'(tgt_ready), 32'd0);
            end
            if (prev_busy && !busy) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: transfer completed with nothing expected at %0t", $time);
                end else begin
                    mon_e = sb.pop_front();
                    chk("exc_pulses", 32'(n_exc), mon_e.chg ? 32'd1 : 32'd0);
                    chk("busy_cycles", 32'(n_busy), mon_e.chg ? 32'd3 : 32'd1);
                    if (mon_e.chg) begin
                        chk("j_out", 32'(cap_j), 32'(mon_e.j));
                        chk("k_out", 32'(cap_k), 32'(mon_e.k));
                    end
                    chk("toggle_cnt", 32'(toggle_cnt), 32'(mon_e.cnt));
                    chk("mismatch", 32'(mismatch), 32'(mon_e.mm));
                    chk("ready_back", 32'(tgt_ready), 32'd1);
                end
                n_exc  = 0;
                n_busy = 0;
            end
            prev_busy = busy;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!tgt_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(tgt_ready), 32'd1);
    endtask

    // One transfer; optional q_fb override and clr_err during the check cycle,
    // optional junk held on tgt_valid/tgt_data while the driver is busy.
    task automatic send(input logic [W-1:0] t, input bit frc, input logic [W-1:0] fv,
                        input bit clr, input bit junk);
        bit   chg;
        exp_t e;
        logic [2*W-1:0] jk;
        wait_ready();
        chg = (t != m_shadow);
        jk  = exp_jk(m_shadow, t);
        if (chg) begin
            m_cnt = m_cnt + $countones(t ^ m_shadow);
            if (m_cnt > int'(CMAX)) m_cnt = int'(CMAX);
        end
        m_mm     = (frc && (fv != t)) | (m_mm & ~clr);
        m_shadow = t;
        e.chg = chg;
        e.j   = jk[2*W-1:W];
        e.k   = jk[W-1:0];
        e.cnt = C'(m_cnt);
        e.mm  = m_mm;
        sb.push_back(e);

        tgt_valid = 1'b1;
        tgt_data  = t;
        @(posedge clk); #1;
        tgt_valid = junk;
        tgt_data  = W'($urandom);
        fb_force  = frc;
        fb_val    = fv;
        repeat (chg ? 2 : 0) begin @(posedge clk); #1; end
        clr_err = clr;
        @(posedge clk); #1;
        clr_err   = 1'b0;
        fb_force  = 1'b0;
        tgt_valid = 1'b0;
    endtask

    initial begin
        int n;
        logic [W-1:0] t;

        // Reset state
        #2;
        chk("rst_j", 32'(j_out), 32'd0);
        chk("rst_k", 32'(k_out), 32'd0);
        chk("rst_exc", 32'(exc_valid), 32'd0);
        chk("rst_mm", 32'(mismatch), 32'd0);
        chk("rst_cnt", 32'(toggle_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(tgt_ready), 32'd1);

        // Directed sequence
        send(4'b1010, 1'b0, '0, 1'b0, 1'b0);
        send(4'b0110, 1'b0, '0, 1'b0, 1'b1);
        send(4'b0110, 1'b0, '0, 1'b0, 1'b0);
        send(4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0);
        send(4'b0001, 1'b0, '0, 1'b0, 1'b0);
        send(4'b0010, 1'b1, 4'b0000, 1'b1, 1'b0);

        // clr_err alone clears the flag
        wait_ready();
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        m_mm = 1'b0;
        @(negedge clk);
        chk("clr_alone", 32'(mismatch), 32'(m_mm));

        // Randomized transfers
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(W'($urandom), ($urandom_range(0, 5) == 0), W'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
        end

        // Reset asserted during SETTLE abandons the transfer
        wait_ready();
        t = ~m_shadow;
        tgt_valid = 1'b1;
        tgt_data  = t;
        @(posedge clk); #1;
        tgt_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("arst_j", 32'(j_out), 32'd0);
        chk("arst_k", 32'(k_out), 32'd0);
        chk("arst_exc", 32'(exc_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_mm", 32'(mismatch), 32'd0);
        chk("arst_cnt", 32'(toggle_cnt), 32'd0);
        repeat (3) @(negedge clk);
        reset_n  = 1'b1;
        m_shadow = '0;
        m_cnt    = 0;
        m_mm     = 1'b0;
        send(4'b0000, 1'b0, '0, 1'b0, 1'b0);

        // Counter saturation
        for (int i = 0; i < 70; i++) begin
            send((i % 2 == 0) ? 4'b1111 : 4'b0000, 1'b0, '0, 1'b0, 1'b0);
        end

        n = 0;
        while (sb.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("cnt_saturated", 32'(toggle_cnt), 32'(CMAX));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
